// File: rtl/can_destuff_ctrl.sv
// Receive-side CAN bit destuffing controller: forwards data bits, drops stuff bits, tracks runs.
// Optional stuff-violation checking is enabled with `define CAN_STUFF_ERR_CHECK_EN.
module can_destuff_ctrl #(
    parameter int RUN_LEN = 5,
    parameter int CNT_W   = 3
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Restart,
    input  logic             i_Enable,
    input  logic             i_Bit_Valid,
    input  logic             i_Bit,
    output logic             o_Bit_Valid,
    output logic             o_Bit,
    output logic             o_Stuff_Skip,
    output logic [CNT_W-1:0] o_Run_Cnt,
    output logic             o_Stuff_Err
);

    typedef enum logic [1:0] {IDLE, COUNT, SKIP, ERR} state_t;

    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state, state_n, cur_state;
    logic [CNT_W-1:0] run_cnt, cnt_n, cur_cnt, run_inc;
    logic             last_bit, last_n;
    logic             valid_n, bit_n, skip_n;
    logic             err_q, err_n;
    logic             stuff_viol;

`ifdef CAN_STUFF_ERR_CHECK_EN
    assign stuff_viol  = (i_Bit == last_bit);
    assign o_Stuff_Err = err_q;
`else
    assign stuff_viol  = 1'b0;
    assign o_Stuff_Err = 1'b0;
`endif

    assign o_Run_Cnt = run_cnt;

    always_comb begin
        // Restart is folded in ahead of bit handling so a coincident bit starts a fresh frame.
        cur_state = i_Restart ? IDLE : state;
        cur_cnt   = i_Restart ? '0 : run_cnt;
        run_inc   = (cur_cnt >= RUN_MAX) ? RUN_MAX : cur_cnt + ONE;

        state_n = cur_state;
        cnt_n   = cur_cnt;
        last_n  = last_bit;
        valid_n = 1'b0;
        bit_n   = o_Bit;
        skip_n  = 1'b0;
        err_n   = i_Restart ? 1'b0 : err_q;

        if (i_Bit_Valid) begin
            case (cur_state)
                IDLE: begin
                    valid_n = 1'b1;
                    bit_n   = i_Bit;
                    if (i_Enable) begin
                        last_n  = i_Bit;
                        cnt_n   = ONE;
                        state_n = (ONE == RUN_MAX) ? SKIP : COUNT;
                    end else begin
                        cnt_n = '0;
                    end
                end
                COUNT: begin
                    valid_n = 1'b1;
                    bit_n   = i_Bit;
                    last_n  = i_Bit;
                    if (!i_Enable) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = (i_Bit == last_bit && cur_cnt != '0) ? run_inc : ONE;
                        if (cnt_n == RUN_MAX) state_n = SKIP;
                    end
                end
                SKIP: begin
                    if (stuff_viol) begin
                        err_n   = 1'b1;
                        state_n = ERR;
                    end else begin
                        // Pending stuff bit is consumed even after the window has closed.
                        skip_n  = 1'b1;
                        last_n  = i_Bit;
                        cnt_n   = i_Enable ? ONE : '0;
                        state_n = i_Enable ? COUNT : IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state        <= IDLE;
            run_cnt      <= '0;
            last_bit     <= 1'b0;
            o_Bit_Valid  <= 1'b0;
            o_Bit        <= 1'b0;
            o_Stuff_Skip <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state        <= state_n;
            run_cnt      <= cnt_n;
            last_bit     <= last_n;
            o_Bit_Valid  <= valid_n;
            o_Bit        <= bit_n;
            o_Stuff_Skip <= skip_n;
            err_q        <= err_n;
        end
    end

endmodule
